uart_axil_tx_feeder: RTL and testbench
======================================

# uart_axil_tx_feeder

AXI-Lite master that drains a byte stream into the UART peripheral's TX data register. It sits directly upstream of the UART AXI-Lite slave and connects to its AW/W/B/AR/R channels. For each byte it optionally polls the status register until the TX FIFO is not full, then issues a single-beat write of the byte. It also counts bus error responses.

## Interface
- DATA_WIDTH, 32: AXI-Lite data width; only 32 is supported.
- ADDR_WIDTH, 32: AXI-Lite address width.
- TXDATA_ADDR, 32'h0: byte address of the UART TX data register.
- STATUS_ADDR, 32'h8: byte address of the UART status register.
- TX_FULL_BIT, 1: bit index of the TX-FIFO-full flag in the status word.
- POLL_GAP, 4: idle cycles inserted between consecutive status polls; range 1..255.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  8  byte to transmit.
- s_tvalid  in  1  byte valid.
- s_tready  out  1  byte accepted when s_tvalid && s_tready.
- awaddr/awvalid/awready  out/out/in  ADDR_WIDTH/1/1  write address channel.
- wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  read address channel.
- rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/2/1/1  read data channel.
- busy  out  1  high whenever the FSM is not in IDLE.
- err_count  out  8  number of non-OKAY BRESP or RRESP responses; saturates at 255.

## Operation
- FSM states: IDLE, AR, R, GAP, WR, B.
- IDLE: s_tready=1. On accept, s_tdata is latched into a holding register. The next state is AR when polling is compiled in, otherwise WR.
- AR: arvalid=1 and araddr=STATUS_ADDR, held until arready. Go to R.
- R: rready=1. On rvalid:
  - rresp!=0: increment err_count, treat the FIFO as full, go to GAP.
  - rdata[TX_FULL_BIT]=1: go to GAP.
  - otherwise: go to WR.
- GAP: the counter loads POLL_GAP-1 on entry and decrements each cycle. Go to AR when it reaches 0.
- WR: awvalid and wvalid rise together on state entry.
  - awaddr=TXDATA_ADDR, wdata={24'b0, byte}, wstrb=4'b0001.
  - Each valid drops independently on its own handshake. A per-channel "done" flag records completion.
  - Go to B once both flags are set, including the case where both handshakes occur in the same cycle.
- B: bready=1. On bvalid, increment err_count if bresp!=0, then go to IDLE.
  - A write error is not retried; the byte is dropped.
- Address, data and strobe outputs hold stable while their valid is high. Valids never drop before their ready.
- Only one transaction is outstanding at any time.

## Timing
- Reset values: all valid signals 0, bready=0, rready=0, s_tready=0, busy=0, err_count=0, awaddr/araddr/wdata=0, wstrb=0. State is IDLE.
- The first cycle after rst deasserts is IDLE, so s_tready=1.
- With zero-wait slaves and polling enabled, the minimum cycle sequence per byte is: accept, AR, R, WR, B. That is 5 cycles, so s_tready returns high 5 cycles after the accept.
- Without polling the sequence is accept, WR, B: 3 cycles.
- Each FULL poll adds POLL_GAP + 2 cycles.
- rst asserted mid-transaction immediately clears all valids, the FSM state and err_count. Any in-flight slave response after reset is ignored.
- err_count increments at most once per cycle. It holds at 255.

## Configuration
- UART_AXIL_TX_POLL_EN:
  - Defined: states AR, R and GAP exist and each byte is status-gated as described above.
  - Undefined: the FSM goes straight from accept to WR, and the AR/R channels stay idle (arvalid=0, rready=0, araddr=0).
  - In this case the UART FIFO drops bytes when full, and the sender is responsible for pacing.

## Test plan
- Polling on, zero-wait slave, status=0, send 0xA5:
  - Expected: AR to 0x8, then AW to 0x0 with wdata=0x000000A5 and wstrb=0x1.
  - s_tready high again 5 cycles after the accept.
- Status returns bit1=1 twice, then 0, POLL_GAP=4:
  - Expected: exactly 3 reads, each later read 6 cycles after the previous, then 1 write.
- Slave raises awready 3 cycles before wready:
  - Expected: awvalid drops after its handshake, wvalid holds, bready asserts only after both handshakes.
  - One B is consumed.
- bresp=2'b10 on 3 writes and rresp=2'b11 on 1 read:
  - Expected: err_count=4. Write-errored bytes are not rewritten.
- rst pulsed while in WR with awvalid=1:
  - Expected: awvalid=wvalid=0 in the same cycle and busy=0.
  - s_tready=1 on the first cycle after release.
- Macro undefined, 10 back-to-back bytes:
  - Expected: arvalid never asserts, 10 writes in order, 3 cycles per byte.

Source files
------------

// File: rtl/uart_axil_tx_feeder.sv
// uart_axil_tx_feeder: AXI-Lite master that writes a byte stream into the UART
// TX data register, one single-beat write per byte, and counts error responses.
// Optional feature macro: UART_AXIL_TX_POLL_EN. When defined, each byte is gated
// by polling the UART status register until the TX-FIFO-full flag reads clear.
module uart_axil_tx_feeder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TXDATA_ADDR = 32'h0,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 32'h8,
  parameter int                    TX_FULL_BIT = 1,
  parameter int                    POLL_GAP    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    busy,
  output logic [7:0]              err_count
);

  localparam logic [DATA_WIDTH/8-1:0] STRB_BYTE0 = {{(DATA_WIDTH/8-1){1'b0}}, 1'b1};
  localparam logic [7:0]              ERR_MAX    = 8'hFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
`ifdef UART_AXIL_TX_POLL_EN
    AR   = 3'd1,
    R    = 3'd2,
    GAP  = 3'd3,
`endif
    WR   = 3'd4,
    B    = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] byte_reg;
  logic       aw_done;
  logic       w_done;
  logic       aw_hs;
  logic       w_hs;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

`ifdef UART_AXIL_TX_POLL_EN
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);
  logic [7:0] gap_cnt;
  logic       unused_rdata;
  // only the full flag of the status word matters
  assign unused_rdata = ^rdata;
`else
  logic unused_poll;
  // read channels are idle without polling
  assign araddr  = '0;
  assign arvalid = 1'b0;
  assign rready  = 1'b0;
  assign unused_poll = ^{arready, rdata, rresp, rvalid, byte_reg,
                         STATUS_ADDR, TX_FULL_BIT, POLL_GAP};
`endif

  // Transaction sequencer: every bus output is a register updated on transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s_tready  <= 1'b0;
      busy      <= 1'b0;
      byte_reg  <= '0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      bready    <= 1'b0;
      err_count <= '0;
`ifdef UART_AXIL_TX_POLL_EN
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      gap_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          s_tready <= 1'b1;
          if (s_tvalid && s_tready) begin
            s_tready <= 1'b0;
            busy     <= 1'b1;
            byte_reg <= s_tdata;
`ifdef UART_AXIL_TX_POLL_EN
            state    <= AR;
            arvalid  <= 1'b1;
            araddr   <= STATUS_ADDR;
`else
            state    <= WR;
            awvalid  <= 1'b1;
            wvalid   <= 1'b1;
            awaddr   <= TXDATA_ADDR;
            wdata    <= {{(DATA_WIDTH-8){1'b0}}, s_tdata};
            wstrb    <= STRB_BYTE0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
`endif
          end
        end
`ifdef UART_AXIL_TX_POLL_EN
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready <= 1'b0;
            // an errored status read is treated as "FIFO full" and retried
            if (rresp != 2'b00 || rdata[TX_FULL_BIT]) begin
              if (rresp != 2'b00 && err_count != ERR_MAX) err_count <= err_count + 8'd1;
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state   <= WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= TXDATA_ADDR;
              wdata   <= {{(DATA_WIDTH-8){1'b0}}, byte_reg};
              wstrb   <= STRB_BYTE0;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state   <= AR;
            arvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
`endif
        WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // both channels may complete in the same cycle
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready   <= 1'b0;
            // a failed write is counted but never retried
            if (bresp != 2'b00 && err_count != ERR_MAX) err_count <= err_count + 8'd1;
            state    <= IDLE;
            s_tready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          s_tready <= 1'b0;
          busy     <= 1'b0;
          awvalid  <= 1'b0;
          wvalid   <= 1'b0;
          bready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axil_tx_feeder.sv
// Testbench for uart_axil_tx_feeder: reactive AXI-Lite slave model with scripted
// responses, expected bytes queued on send and compared as writes appear.
module tb_uart_axil_tx_feeder;

  localparam int POLL_GAP = 4;
`ifdef UART_AXIL_TX_POLL_EN
  localparam bit POLL = 1'b1;
  localparam int LAT  = 5;
`else
  localparam bit POLL = 1'b0;
  localparam int LAT  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        busy;
  logic [7:0]  err_count;

  uart_axil_tx_feeder #(.POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // slave configuration and response scripts (written by the test sequence only)
  int          aw_lat = 0;
  int          w_lat  = 0;
  logic [33:0] r_script[$];
  logic [1:0]  b_script[$];

  // slave state and logs (written by the slave process only)
  int          r_idx = 0, b_idx = 0, aw_cnt = 0, w_cnt = 0;
  bit          aw_got, w_got, b_pend, r_pend, b_fire, r_fire, aw_wait, w_wait;
  int          writes = 0, reads = 0, bcount = 0, ar_high = 0, drop_viol = 0;
  logic [31:0] aw_log[$];
  logic [35:0] w_log[$];
  logic [31:0] ar_log[$];
  int          ar_cyc[$];

  // scoreboard (written by the test sequence only)
  logic [7:0]  exp_q[$];
  int          e_ptr = 0, w_ptr = 0, a_ptr = 0, r_ptr = 0;
  int          checks = 0, errors = 0;

  // Slave: drives readies/responses on the falling edge; a handshake seen here
  // completes at the following rising edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      b_fire = 0; r_fire = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if ((aw_wait && !awvalid) || (w_wait && !wvalid)) drop_viol++;
      if (b_fire) begin bvalid = 1'b0; b_fire = 0; end
      if (r_fire) begin rvalid = 1'b0; r_fire = 0; end
      if (b_pend) begin
        bvalid = 1'b1;
        bresp  = 2'b00;
        if (b_idx < b_script.size()) begin bresp = b_script[b_idx]; b_idx++; end
        b_pend = 0;
      end
      if (r_pend) begin
        rvalid = 1'b1;
        {rresp, rdata} = 34'h0;
        if (r_idx < r_script.size()) begin {rresp, rdata} = r_script[r_idx]; r_idx++; end
        r_pend = 0;
      end
      if (awvalid) begin
        if (aw_cnt >= aw_lat) awready = 1'b1;
        else begin awready = 1'b0; aw_cnt++; end
      end else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin
        if (w_cnt >= w_lat) wready = 1'b1;
        else begin wready = 1'b0; w_cnt++; end
      end else begin wready = 1'b0; w_cnt = 0; end
      arready = arvalid;
      if (awvalid && awready) begin aw_log.push_back(awaddr); aw_got = 1; end
      if (wvalid && wready) begin w_log.push_back({wstrb, wdata}); w_got = 1; end
      if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; writes++; end
      if (arvalid) ar_high++;
      if (arvalid && arready) begin ar_log.push_back(araddr); ar_cyc.push_back(cyc); r_pend = 1; reads++; end
      if (bvalid && bready) begin b_fire = 1; bcount++; end
      if (rvalid && rready) r_fire = 1;
      aw_wait = awvalid && !awready;
      w_wait  = wvalid && !wready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (s_tready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (s_tready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: s_tready=%b after %0d cycles, required 1", tag, s_tready, n);
    end
  endtask

  // called on a falling edge; returns on the falling edge after the accept
  task automatic send(input logic [7:0] b, output int acc);
    wait_ready("send");
    s_tdata  = b;
    s_tvalid = 1'b1;
    acc      = cyc;
    exp_q.push_back(b);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  // compare every logged bus transaction against the scoreboard
  task automatic drain(input string tag);
    logic [35:0] got;
    while (w_ptr < w_log.size()) begin
      got = w_log[w_ptr];
      checks++;
      if (e_ptr >= exp_q.size()) begin
        errors++;
        $display("FAIL %s_wdata: unexpected write strb=%h data=%h, none expected", tag, got[35:32], got[31:0]);
      end else begin
        if (got !== {4'h1, 24'h0, exp_q[e_ptr]}) begin
          errors++;
          $display("FAIL %s_wdata: got strb=%h data=%h, required strb=1 data=%h", tag, got[35:32], got[31:0], {24'h0, exp_q[e_ptr]});
        end else begin
          $display("write %0d: data=%h strb=%h", w_ptr, got[31:0], got[35:32]);
        end
        e_ptr++;
      end
      w_ptr++;
    end
    while (a_ptr < aw_log.size()) begin
      checks++;
      if (aw_log[a_ptr] !== 32'h0) begin
        errors++;
        $display("FAIL %s_awaddr: got %h, required 00000000", tag, aw_log[a_ptr]);
      end
      a_ptr++;
    end
    while (r_ptr < ar_log.size()) begin
      checks++;
      if (ar_log[r_ptr] !== 32'h8) begin
        errors++;
        $display("FAIL %s_araddr: got %h, required 00000008", tag, ar_log[r_ptr]);
      end else begin
        $display("status read %0d at cycle %0d", r_ptr, ar_cyc[r_ptr]);
      end
      r_ptr++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_tready, busy, awvalid, wvalid, arvalid, rready, bready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: tready/busy/awv/wv/arv/rr/br=%b, required 0000000",
               {s_tready, busy, awvalid, wvalid, arvalid, rready, bready});
    end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d, required 0", err_count); end
    checks++;
    if ({awaddr, araddr, wdata, wstrb} !== 100'b0) begin
      errors++;
      $display("FAIL reset_bus: awaddr=%h araddr=%h wdata=%h wstrb=%h, required all 0", awaddr, araddr, wdata, wstrb);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_tready=%b busy=%b, required 1 0", s_tready, busy);
    end
  endtask

  task automatic test_basic();
    int a, w0, r0;
    w0 = writes; r0 = reads;
    send(8'hA5, a);
    checks++;
    if (busy !== 1'b1 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b s_tready=%b, required 1 0", busy, s_tready);
    end
    wait_ready("basic");
    checks++;
    if (cyc - a !== LAT) begin errors++; $display("FAIL basic_latency: got %0d cycles, required %0d", cyc - a, LAT); end
    drain("basic");
    checks++;
    if (writes - w0 !== 1) begin errors++; $display("FAIL basic_writes: got %0d, required 1", writes - w0); end
    checks++;
    if (reads - r0 !== (POLL ? 1 : 0)) begin errors++; $display("FAIL basic_reads: got %0d, required %0d", reads - r0, POLL ? 1 : 0); end
  endtask

  task automatic test_full_poll();
`ifdef UART_AXIL_TX_POLL_EN
    int a, w0, r0, i0;
    w0 = writes; r0 = reads; i0 = ar_cyc.size();
    r_script.push_back({2'b00, 32'h0000_0002});
    r_script.push_back({2'b00, 32'h0000_0002});
    send(8'h3E, a);
    wait_ready("full_poll");
    drain("full_poll");
    checks++;
    if (reads - r0 !== 3) begin errors++; $display("FAIL full_poll_reads: got %0d, required 3", reads - r0); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (ar_cyc.size() < i0 + 3) begin
        errors++; $display("FAIL full_poll_gap%0d: only %0d reads logged, required 3", i, ar_cyc.size() - i0);
      end else if (ar_cyc[i0 + i] - ar_cyc[i0 + i - 1] !== POLL_GAP + 2) begin
        errors++;
        $display("FAIL full_poll_gap%0d: got %0d cycles, required %0d", i, ar_cyc[i0 + i] - ar_cyc[i0 + i - 1], POLL_GAP + 2);
      end
    end
    checks++;
    if (writes - w0 !== 1) begin errors++; $display("FAIL full_poll_writes: got %0d, required 1", writes - w0); end
`endif
  endtask

  task automatic test_aw_early();
    int a, held, bad, n, b0;
    held = 0; bad = 0; n = 0; b0 = bcount;
    aw_lat = 0; w_lat = 3;
    send(8'h5A, a);
    while (s_tready !== 1'b1 && n < 100) begin
      if (awvalid === 1'b0 && wvalid === 1'b1) held++;
      if (bready === 1'b1 && (awvalid === 1'b1 || wvalid === 1'b1)) bad++;
      @(negedge clk);
      n++;
    end
    w_lat = 0;
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL aw_early_timeout: s_tready=%b, required 1", s_tready); end
    checks++;
    if (held !== 3) begin errors++; $display("FAIL aw_early_wheld: wvalid alone for %0d cycles, required 3", held); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL aw_early_bready: bready early in %0d cycles, required 0", bad); end
    checks++;
    if (bcount - b0 !== 1) begin errors++; $display("FAIL aw_early_bcount: got %0d, required 1", bcount - b0); end
    drain("aw_early");
  endtask

  task automatic test_errors();
    int a, w0, r0, b0;
    w0 = writes; r0 = reads; b0 = bcount;
`ifdef UART_AXIL_TX_POLL_EN
    r_script.push_back({2'b11, 32'h0});
`endif
    repeat (3) b_script.push_back(2'b10);
    send(8'h11, a);
    send(8'h22, a);
    send(8'h33, a);
    wait_ready("errors");
    drain("errors");
    checks++;
    if (err_count !== (POLL ? 8'd4 : 8'd3)) begin
      errors++; $display("FAIL errors_count: got %0d, required %0d", err_count, POLL ? 4 : 3);
    end
    checks++;
    if (writes - w0 !== 3) begin errors++; $display("FAIL errors_writes: got %0d, required 3", writes - w0); end
    checks++;
    if (bcount - b0 !== 3) begin errors++; $display("FAIL errors_bcount: got %0d, required 3", bcount - b0); end
    checks++;
    if (reads - r0 !== (POLL ? 4 : 0)) begin errors++; $display("FAIL errors_reads: got %0d, required %0d", reads - r0, POLL ? 4 : 0); end
  endtask

  task automatic test_reset_mid();
    int a, n;
    n = 0;
    aw_lat = 30; w_lat = 30;
    send(8'hC3, a);
    while (awvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (awvalid !== 1'b1) begin errors++; $display("FAIL reset_mid_reach: awvalid=%b, required 1", awvalid); end
    rst = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_clear: awv/wv/busy=%b, required 000", {awvalid, wvalid, busy});
    end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_mid_err: got %0d, required 0", err_count); end
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    aw_lat = 0; w_lat = 0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_mid_release: s_tready=%b, required 1", s_tready); end
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    int acc[10];
    int w0, h0;
    w0 = writes; h0 = ar_high;
    for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), acc[i]);
    wait_ready("b2b");
    drain("b2b");
    for (int i = 1; i < 10; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== LAT) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", i, acc[i] - acc[i-1], LAT);
      end
    end
    checks++;
    if (writes - w0 !== 10) begin errors++; $display("FAIL b2b_writes: got %0d, required 10", writes - w0); end
`ifdef UART_AXIL_TX_POLL_EN
    checks++;
    if (ar_high - h0 !== 10) begin errors++; $display("FAIL b2b_arvalid: high %0d cycles, required 10", ar_high - h0); end
`else
    checks++;
    if (ar_high !== 0) begin errors++; $display("FAIL b2b_arvalid: high %0d cycles, required 0", ar_high); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_poll();
    test_aw_early();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    drain("final");
    checks++;
    if (e_ptr !== exp_q.size()) begin
      errors++; $display("FAIL final_pending: %0d bytes written, required %0d", e_ptr, exp_q.size());
    end
    checks++;
    if (drop_viol !== 0) begin
      errors++; $display("FAIL valid_drop: %0d valids dropped before ready, required 0", drop_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
